interval_timer: RTL and testbench
=================================

# interval_timer

Preemption timer for the FPG8 datapath. It is loaded from the internal bus when the control unit asserts `timer_in`. It counts down in user mode and raises a sticky `timeout` flag. The control unit samples `timeout` at every instruction boundary and, in user mode, diverts to the T1 trap sequence instead of F1.

## Interface
Parameters:
- `WIDTH`, 16: counter and bus width.
- `PRESCALE`, 1: clocks per count decrement (≥1). 1 means decrement every enabled clock.
- `COUNT_IN_PRIV`, 0: 1 means the counter also runs while `privileged`=1.

Ports:
- `clk`, in, 1: system clock. Every register updates on the rising edge.
- `reset`, in, 1: synchronous, active-high. Sampled on the rising edge of `clk`.
- `timer_in`, in, 1: load strobe from the control unit (state E14_2).
- `bus_in`, in, WIDTH: datapath bus. This is the load value when `timer_in`=1.
- `privileged`, in, 1: PSW bit 2.
- `timeout`, out, 1: sticky expiry flag. Connects to the control unit's `timeout` input.
- `count_out`, out, WIDTH: current counter value, for debug/LED display.
- `armed`, out, 1: timer is loaded with a nonzero value and has not yet expired.

## Operation
Registers:
- `count` [WIDTH]
- `presc` [ceil(log2(PRESCALE+1))]
- `armed`
- `timeout`

Reset (`reset`=1 at an edge):
- `count`=0, `presc`=0, `armed`=0, `timeout`=0.
- Reset overrides every other input on that edge.
- Reset mid-count discards the count. No timeout is produced.

States (derived from `armed`/`timeout`):
- IDLE: `armed`=0, `timeout`=0.
- RUN: `armed`=1.
- EXPIRED: `armed`=0, `timeout`=1.

Load (`timer_in`=1, not reset):
- `count` ← `bus_in`, `presc` ← 0, `timeout` ← 0.
- `armed` ← (`bus_in`≠0).
- A load of 0 disarms the timer and clears `timeout`. The next state is IDLE.
- A load is accepted in any state and any mode. Load has priority over a tick on the same edge.

Enable: `en` = `armed` & (~`privileged` | `COUNT_IN_PRIV`).

Tick (when `en`=1 and no load):
- If `presc` = PRESCALE-1: `presc` ← 0 and `count` ← `count`-1. Otherwise `presc` ← `presc`+1.
- When a decrement takes `count` from 1 to 0 on the same edge: `timeout` ← 1 and `armed` ← 0. The next state is EXPIRED.
- `count` never wraps. With `armed`=0, no decrement occurs, so 0 is terminal.

Freeze: while `en`=0, `count` and `presc` hold their values. A user→privileged→user round trip resumes counting exactly where it stopped.

EXPIRED:
- `timeout` stays 1 until a load or reset. Privileged mode does not clear it.
- If the OS returns to user mode without reloading, the control unit traps again at the next boundary. This is intended.

Outputs:
- `timeout`, `armed` and `count_out` are driven directly from registers.
- No combinational path exists from inputs to outputs.

## Timing
- Load latency: `count_out`=`bus_in` in the cycle after the `timer_in` edge.
- The first decrement occurs PRESCALE enabled clocks after the load edge.
- Expiry: a load of N (N>0) with `en` held at 1 throughout gives `timeout`=1 exactly N×PRESCALE clocks after the load edge.
- `timeout` is visible to the control unit's next-state logic on the cycle it rises. An instruction boundary coincident with the rising edge that sets `timeout` still goes to F1. The trap is taken at the following boundary.
- `privileged` is sampled every edge. A change takes effect on the same edge it is sampled.

## Test plan
- Reset: hold `reset` 2 cycles during RUN with `count`=0x0040 → `count_out`=0, `timeout`=0 and `armed`=0 on the next cycle. No timeout occurs in the following 100 cycles.
- Basic expiry (PRESCALE=1, `privileged`=0):
  - Load 0x0005 at cycle 0 → `count_out` reads 5,4,3,2,1.
  - `timeout`=1 and `armed`=0 from cycle 5.
  - `timeout` holds for 20 cycles.
- Freeze:
  - Load 10 and run 3 cycles (`count`=7).
  - Set `privileged`=1 for 8 cycles → `count` stays at 7.
  - Clear `privileged` → `timeout` at 7 cycles later.
  - Repeat with COUNT_IN_PRIV=1 → `timeout` at cycle 10.
- Load collisions:
  - Load 3; at the edge where `count` 1→0, also assert `timer_in` with 0x0004 → `timeout` stays 0 and `count_out`=4.
  - Then load 0 → `armed`=0 and no expiry.
- Prescaler (PRESCALE=4): load 2 → `count_out` changes at cycles 4 and 8, and `timeout` rises at cycle 8. `presc` resets on reload.
- Sticky clear: after expiry, set `privileged`=1 for 5 cycles → `timeout` stays 1. A load of 0x0100 clears `timeout` on the next cycle.

Source files
------------

// File: rtl/interval_timer.sv
// interval_timer
//   Preemption timer. Loaded from the datapath bus on timer_in, counts down
//   while armed and enabled (user mode, or always when COUNT_IN_PRIV=1), and
//   raises a sticky timeout flag when the count reaches zero. The flag stays
//   set until the next load or reset.
//
// Ports
//   clk        : system clock, rising-edge
//   reset      : synchronous active-high reset
//   timer_in   : load strobe; takes priority over a tick on the same edge
//   bus_in     : load value (WIDTH bits)
//   privileged : PSW privileged bit; freezes the count unless COUNT_IN_PRIV=1
//   timeout    : sticky expiry flag (registered)
//   count_out  : current count (registered)
//   armed      : loaded with a nonzero value and not yet expired (registered)
//
// State is implied by the armed/timeout registers:
//   state   | meaning
//   IDLE    | armed=0, timeout=0 : not loaded, or loaded with zero
//   RUN     | armed=1            : counting, or frozen in privileged mode
//   EXPIRED | armed=0, timeout=1 : reached zero; held until reload or reset
module interval_timer #(
  parameter int WIDTH         = 16,
  parameter int PRESCALE      = 1,
  parameter int COUNT_IN_PRIV = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_in,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             privileged,
  output logic             timeout,
  output logic [WIDTH-1:0] count_out,
  output logic             armed
);

  localparam int PW = (PRESCALE < 2) ? 1 : $clog2(PRESCALE + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic             RUN_PRIV   = (COUNT_IN_PRIV != 0);
  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [PW-1:0]    presc;
  logic             en;

  // Armed implies a nonzero count, so a decrement can never wrap.
  assign en = armed & (~privileged | RUN_PRIV);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      presc   <= '0;
      armed   <= 1'b0;
      timeout <= 1'b0;
    end else if (timer_in) begin
      count   <= bus_in;
      presc   <= '0;
      armed   <= (bus_in != '0);
      timeout <= 1'b0;
    end else if (en) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        count <= count - COUNT_ONE;
        if (count == COUNT_ONE) begin
          armed   <= 1'b0;
          timeout <= 1'b1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign count_out = count;

endmodule

// File: tb/tb_interval_timer.sv
module tb_interval_timer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             timer_in;
  logic [WIDTH-1:0] bus_in;
  logic             privileged;

  // u0: PRESCALE=1, frozen in privileged mode
  // u1: PRESCALE=1, counts in privileged mode
  // u2: PRESCALE=4, frozen in privileged mode
  logic             timeout0, timeout1, timeout2;
  logic             armed0, armed1, armed2;
  logic [WIDTH-1:0] count0, count1, count2;

  interval_timer #(.WIDTH(WIDTH), .PRESCALE(1), .COUNT_IN_PRIV(0)) u0 (
    .clk(clk), .reset(reset), .timer_in(timer_in), .bus_in(bus_in),
    .privileged(privileged), .timeout(timeout0), .count_out(count0), .armed(armed0));

  interval_timer #(.WIDTH(WIDTH), .PRESCALE(1), .COUNT_IN_PRIV(1)) u1 (
    .clk(clk), .reset(reset), .timer_in(timer_in), .bus_in(bus_in),
    .privileged(privileged), .timeout(timeout1), .count_out(count1), .armed(armed1));

  interval_timer #(.WIDTH(WIDTH), .PRESCALE(4), .COUNT_IN_PRIV(0)) u2 (
    .clk(clk), .reset(reset), .timer_in(timer_in), .bus_in(bus_in),
    .privileged(privileged), .timeout(timeout2), .count_out(count2), .armed(armed2));

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge; returns 1 time unit after it so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    timer_in = 1'b1;
    bus_in   = v;
    step();
    timer_in = 1'b0;
    bus_in   = '0;
  endtask

  initial begin
    logic seen;
    reset      = 1'b1;
    timer_in   = 1'b0;
    bus_in     = '0;
    privileged = 1'b0;
    #2;

    // Reset state
    step(); step();
    reset = 1'b0;
    check("rst_count", count0, 0);
    check("rst_armed", armed0, 0);
    check("rst_timeout", timeout0, 0);

    // Reset mid-count discards the count
    load(16'h0040);
    check("run_count", count0, 16'h0040);
    check("run_armed", armed0, 1);
    step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_mid_count", count0, 0);
    check("rst_mid_armed", armed0, 0);
    check("rst_mid_timeout", timeout0, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (timeout0 || count0 != 0) seen = 1'b1;
    end
    check("rst_no_timeout_100", seen, 0);

    // Basic expiry: load 5 -> 5,4,3,2,1 then timeout at cycle 5
    load(16'h0005);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      check("basic_count", count0, 5 - c);
      check("basic_no_timeout", timeout0, 0);
    end
    step();
    check("basic_timeout", timeout0, 1);
    check("basic_armed", armed0, 0);
    check("basic_count_zero", count0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!timeout0 || count0 != 0) seen = 1'b1;
    end
    check("basic_timeout_held", seen, 0);

    // Freeze: load 10, 3 user cycles, 8 privileged, then user again
    load(16'd10);
    step(); step(); step();
    check("frz_count7_u0", count0, 7);
    check("frz_count7_u1", count1, 7);
    privileged = 1'b1;
    for (int c = 4; c <= 11; c++) begin
      step();
      check("frz_hold_u0", count0, 7);
      if (c == 9)  check("frz_priv_pre_u1", timeout1, 0);
      if (c == 10) check("frz_priv_timeout_u1", timeout1, 1);
    end
    check("frz_no_timeout_u0", timeout0, 0);
    privileged = 1'b0;
    for (int c = 12; c <= 18; c++) begin
      step();
      if (c == 17) check("frz_resume_pre_u0", timeout0, 0);
    end
    check("frz_resume_timeout_u0", timeout0, 1);
    check("frz_resume_count_u0", count0, 0);

    // Load collision at the 1->0 edge: load wins
    load(16'd3);
    step(); step();
    check("coll_count1", count0, 1);
    load(16'd4);
    check("coll_timeout", timeout0, 0);
    check("coll_count", count0, 4);
    check("coll_armed", armed0, 1);
    load(16'd0);
    check("load0_armed", armed0, 0);
    check("load0_timeout", timeout0, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (timeout0 || armed0) seen = 1'b1;
    end
    check("load0_no_expiry", seen, 0);

    // Prescaler=4: load 2 -> changes at cycles 4 and 8
    load(16'd2);
    check("psc_load", count2, 2);
    for (int c = 1; c <= 8; c++) begin
      step();
      check("psc_count", count2, (c < 4) ? 2 : (c < 8) ? 1 : 0);
      check("psc_timeout", timeout2, (c == 8) ? 1 : 0);
    end
    load(16'd2);
    step(); step();
    load(16'd2);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("psc_reload_count", count2, (c < 4) ? 2 : 1);
    end

    // Sticky: u0 expired after the last load of 2
    check("sticky_expired", timeout0, 1);
    privileged = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sticky_priv_hold", timeout0, 1);
    end
    load(16'h0100);
    check("sticky_clear", timeout0, 0);
    check("sticky_reload_count", count0, 16'h0100);
    check("sticky_reload_armed", armed0, 1);
    privileged = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
